bg_color_ctrl: RTL
==================

BG_COLOR_CTRL -- requirements
Module: bg_color_ctrl

Interface
REQ-001 SHALL provide parameter FLASH_PERIOD, default 8: frames between flash inversions, legal range 1..256.
REQ-002 SHALL provide parameter FLASH_FLIPS, default 6: inversions per flash sequence, legal range 1..15.
REQ-003 SHALL provide port clk  input  1: pixel clock; the block has one clock.
REQ-004 SHALL provide port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL provide port vsync_in  input  1: frame sync from the VGA timing chain; its rising edge marks the frame boundary.
REQ-006 SHALL provide port theme_req  input  1: requested steady theme (0 = light, 1 = dark); level-sensitive.
REQ-007 SHALL provide port flash_req  input  1: single-cycle request to start a flash sequence.
REQ-008 SHALL provide port color_select  output  1: registered; drives draw_background color_select.
REQ-009 SHALL provide port flash_busy  output  1: registered; high while state = FLASH.
REQ-010 SHALL provide port flash_done  output  1: registered; one-cycle pulse when a flash sequence ends.
REQ-011 SHALL provide port frame_tick  output  1: registered; one-cycle pulse in the cycle after each frame_start.

Function
REQ-012 SHALL register vsync_in into vsync_d and define frame_start = vsync_in AND NOT vsync_d (combinational).
REQ-013 SHALL change color_select only on a clock edge where frame_start = 1, so there is no mid-frame tearing.
REQ-014 SHALL latch flash_req into flash_pend in any cycle in which flash_req is not consumed on that same edge; flash_pend SHALL be cleared when consumed.
REQ-015 SHALL implement a two-state FSM, {STEADY, FLASH}, with internal counters frm_cnt (8 bits) and flips_left (4 bits).
REQ-016 In STEADY on frame_start with (flash_pend OR flash_req) = 0, the block SHALL load color_select <= theme_req.
REQ-017 In STEADY on frame_start with (flash_pend OR flash_req) = 1, the block SHALL:
- go to FLASH;
- load color_select <= NOT theme_req;
- load flips_left <= FLASH_FLIPS-1;
- load frm_cnt <= FLASH_PERIOD-1;
- clear flash_pend.
REQ-018 In FLASH on frame_start with frm_cnt != 0, the block SHALL decrement frm_cnt and hold color_select.
REQ-019 In FLASH on frame_start with frm_cnt = 0 and flips_left != 0, the block SHALL:
- invert color_select;
- decrement flips_left;
- reload frm_cnt <= FLASH_PERIOD-1.
REQ-020 In FLASH on frame_start with frm_cnt = 0 and flips_left = 0 (exit frame), the block SHALL:
- load color_select <= theme_req;
- pulse flash_done for 1 cycle;
- go to STEADY.
REQ-021 If (flash_pend OR flash_req) = 1 on the exit frame, the block SHALL re-enter FLASH per REQ-017 instead of going to STEADY, and flash_done SHALL still pulse.
REQ-022 Without retrigger, the block SHALL make inversions at relative frames 0, P, 2P, ..., (F-1)P and restore theme_req at frame F*P (P = FLASH_PERIOD, F = FLASH_FLIPS).
REQ-023 Between frame_start edges, the block SHALL hold all state; changes on theme_req and flash_req SHALL have no effect on color_select until the next frame_start.
REQ-024 When FLASH_PERIOD = 1, the block SHALL make an inversion on every frame_start; when FLASH_FLIPS = 1, it SHALL make a single inverted frame span of P frames.
REQ-025 flash_busy SHALL equal (next state = FLASH), registered, so that it rises together with the first inverted color_select.

Reset
REQ-026 While rst_n = 0, the block SHALL asynchronously force:
- color_select = 0;
- flash_busy = 0, flash_done = 0, frame_tick = 0;
- state = STEADY;
- frm_cnt = 0, flips_left = 0, flash_pend = 0;
- vsync_d = 1.
REQ-027 After rst_n deasserts with vsync_in already high, the block SHALL NOT detect a false frame_start (guaranteed by vsync_d reset value 1).
REQ-028 When reset asserts mid-FLASH, the block SHALL abort the sequence with no flash_done pulse; it SHALL resume in STEADY and apply theme_req at the first frame_start after reset.

Verification
REQ-029 The bench SHALL cover: theme_req 0->1 mid-frame -> color_select stays 0 until the next vsync rising edge, becomes 1 on that edge, and frame_tick pulses 1 cycle later.
REQ-030 The bench SHALL cover: P=8, F=6, theme_req=0, flash_req pulsed -> color_select = 1,0,1,0,1,0 at relative frames 0,8,16,24,32,40; flash_done pulses at frame 48 with color_select = 0; flash_busy is high for frames 0..47.
REQ-031 The bench SHALL cover: flash_req pulsed 3 frames into a sequence -> no restart; re-entry at frame F*P with color_select = NOT theme_req, and flash_done pulses at that frame.
REQ-032 The bench SHALL cover: flash_req coincident with frame_start in STEADY -> FLASH is entered on that same edge, and flash_pend remains 0.
REQ-033 The bench SHALL cover: rst_n pulsed low at frame 20 of a flash -> outputs drop to 0 immediately; with vsync_in held high across release, there is no transition until the next rising edge.
REQ-034 The bench SHALL cover: P=1, F=1, theme_req=1 -> color_select = 0 for exactly 1 frame, then 1, with flash_done pulsing on the restore frame.

Source files
------------

// File: rtl/bg_color_ctrl.sv
// Background theme/flash colour select: updates only on vsync rising edge (registered, 1 cycle after frame_start).
// No backpressure: a flash request arriving mid-sequence is held pending and taken on the exit frame.
module bg_color_ctrl #(
  parameter int FLASH_PERIOD = 8,
  parameter int FLASH_FLIPS  = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  input  logic theme_req,
  input  logic flash_req,
  output logic color_select,
  output logic flash_busy,
  output logic flash_done,
  output logic frame_tick
);

  typedef enum logic {
    STEADY = 1'b0,
    FLASH  = 1'b1
  } state_t;

  localparam logic [7:0] PERIOD_M1 = 8'(FLASH_PERIOD - 1);
  localparam logic [3:0] FLIPS_M1  = 4'(FLASH_FLIPS - 1);

  state_t     state;
  state_t     state_nxt;
  logic       vsync_d;
  logic       frame_start;
  logic [7:0] frm_cnt;
  logic [7:0] frm_cnt_nxt;
  logic [3:0] flips_left;
  logic [3:0] flips_nxt;
  logic       flash_pend;
  logic       pend_nxt;
  logic       color_nxt;
  logic       done_nxt;
  logic       req_any;
  logic       start_seq;

  assign frame_start = vsync_in & ~vsync_d;
  assign req_any     = flash_pend | flash_req;

  always_comb begin
    state_nxt   = state;
    frm_cnt_nxt = frm_cnt;
    flips_nxt   = flips_left;
    color_nxt   = color_select;
    done_nxt    = 1'b0;
    start_seq   = 1'b0;
    if (frame_start) begin
      case (state)
        STEADY: begin
          if (req_any) start_seq = 1'b1;
          else         color_nxt = theme_req;
        end
        FLASH: begin
          if (frm_cnt != 8'd0) begin
            frm_cnt_nxt = frm_cnt - 8'd1;
          end else if (flips_left != 4'd0) begin
            color_nxt   = ~color_select;
            flips_nxt   = flips_left - 4'd1;
            frm_cnt_nxt = PERIOD_M1;
          end else begin
            // exit frame: a pending request chains straight into a new sequence
            done_nxt = 1'b1;
            if (req_any) begin
              start_seq = 1'b1;
            end else begin
              color_nxt = theme_req;
              state_nxt = STEADY;
            end
          end
        end
        default: state_nxt = STEADY;
      endcase
    end
    if (start_seq) begin
      state_nxt   = FLASH;
      color_nxt   = ~theme_req;
      flips_nxt   = FLIPS_M1;
      frm_cnt_nxt = PERIOD_M1;
    end
    pend_nxt = start_seq ? 1'b0 : req_any;
  end

  // vsync_d resets high so a vsync already high at release is not a frame edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= STEADY;
      vsync_d      <= 1'b1;
      frm_cnt      <= 8'd0;
      flips_left   <= 4'd0;
      flash_pend   <= 1'b0;
      color_select <= 1'b0;
      flash_busy   <= 1'b0;
      flash_done   <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      state        <= state_nxt;
      vsync_d      <= vsync_in;
      frm_cnt      <= frm_cnt_nxt;
      flips_left   <= flips_nxt;
      flash_pend   <= pend_nxt;
      color_select <= color_nxt;
      flash_busy   <= (state_nxt == FLASH);
      flash_done   <= done_nxt;
      frame_tick   <= frame_start;
    end
  end

endmodule
